// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - packed BCD to unsigned binary, one digit per clock (option: BCD_TO_BINARY_DIGIT_CHECK_EN)

module bcd_to_binary #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [WIDTH-1:0]      value,
    output logic                  ready,
    output logic                  error
);

    // Counter must be at least one bit wide even for a single-digit build.
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [4*DIGITS-1:0]   sreg;
    logic [WIDTH-1:0]      acc;
    logic [WIDTH-1:0]      acc_next;
    logic [WIDTH-1:0]      nib_ext;
    logic [CW-1:0]         cnt;
    logic [3:0]            nib;

    // Digit under conversion is always the top nibble of the shift register.
    assign nib = sreg[4*DIGITS-1 -: 4];

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic bad_flag;
    logic nib_bad;

    assign nib_bad = (nib > 4'd9);
`else
    // Without digit checking no result can be flagged.
    assign error = 1'b0;
`endif

    // Multiply-by-ten-and-add step, wrapping modulo 2^WIDTH.
    always_comb begin
        nib_ext  = WIDTH'(nib);
        acc_next = (acc << 3) + (acc << 1) + nib_ext;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            value <= '0;
            acc   <= '0;
            cnt   <= '0;
            sreg  <= '0;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
            bad_flag <= 1'b0;
            error    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                state <= RUN;
                ready <= 1'b0;
                sreg  <= bcd;
                acc   <= '0;
                cnt   <= CW'(DIGITS - 1);
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
                bad_flag <= 1'b0;
`endif
            end
        end else begin
            acc  <= acc_next;
            sreg <= sreg << 4;
            cnt  <= cnt - 1'b1;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
            bad_flag <= bad_flag | nib_bad;
`endif
            if (cnt == '0) begin
                // Final digit consumed this edge: publish the result.
                state <= IDLE;
                ready <= 1'b1;
                value <= acc_next;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
                error <= bad_flag | nib_bad;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - randomized self-checking bench for bcd_to_binary

module tb_bcd_to_binary;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;

    logic                clk;
    logic                rst;
    logic                start;
    logic [4*DIGITS-1:0] bcd;
    logic [WIDTH-1:0]    value;
    logic                ready;
    logic                error;

    int n_cmp;
    int n_bad;

    bcd_to_binary #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .value (value),
        .ready (ready),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal positional weighting, reduced modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] ref_value(input logic [4*DIGITS-1:0] b);
        longint v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = (v * 10 + longint'(b[4*i +: 4])) % (longint'(1) << WIDTH);
        end
        return WIDTH'(v);
    endfunction

    function automatic logic ref_error(input logic [4*DIGITS-1:0] b);
        logic e;
        e = 1'b0;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) e = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then follow the run until ready returns.
    task automatic do_conv(input logic [4*DIGITS-1:0] b, output int lows,
                           output logic [WIDTH-1:0] v, output logic e,
                           output logic held);
        logic [WIDTH-1:0] v0;
        logic             e0;
        v0    = value;
        e0    = error;
        held  = 1'b1;
        lows  = 0;
        start = 1'b1;
        bcd   = b;
        tick();
        start = 1'b0;
        bcd   = $urandom;
        while (!ready && lows < 20) begin
            if (value !== v0 || error !== e0) held = 1'b0;
            lows++;
            tick();
        end
        v = value;
        e = error;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        bcd   = 16'h4934;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || value !== '0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: ready=%0b value=%0d error=%0b, want 1/0/0", ready, value, error);
        end
    endtask

    task automatic test_nominal();
        int lows; logic [WIDTH-1:0] v; logic e; logic held;
        do_conv(16'h4934, lows, v, e, held);
        n_cmp++;
        if (lows !== DIGITS) begin
            n_bad++;
            $display("FAIL nominal_latency: ready low %0d cycles, want %0d", lows, DIGITS);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL nominal_hold: value/error changed during run, want held");
        end
        n_cmp++;
        if (v !== 14'd4934 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_4934: value=%0d error=%0b, want 4934/0", v, e);
        end
        do_conv(16'h0000, lows, v, e, held);
        n_cmp++;
        if (v !== 14'd0 || e !== 1'b0 || lows !== DIGITS) begin
            n_bad++;
            $display("FAIL nominal_0000: value=%0d error=%0b lows=%0d, want 0/0/%0d", v, e, lows, DIGITS);
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        start = 1'b1;
        bcd   = 16'h9999;
        tick();
        bcd   = 16'h0001;
        lows  = 0;
        while (!ready && lows < 20) begin
            lows++;
            tick();
        end
        n_cmp++;
        if (lows !== DIGITS || value !== 14'd9999) begin
            n_bad++;
            $display("FAIL b2b_9999: value=%0d lows=%0d, want 9999/%0d", value, lows, DIGITS);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: ready=%0b after held start, want 0", ready);
        end
        for (int i = 0; i < DIGITS - 1; i++) tick();
        n_cmp++;
        if (ready !== 1'b0 || value !== 14'd9999) begin
            n_bad++;
            $display("FAIL b2b_running: ready=%0b value=%0d, want 0/9999", ready, value);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || value !== 14'd1) begin
            n_bad++;
            $display("FAIL b2b_0001: ready=%0b value=%0d, want 1/1", ready, value);
        end
    endtask

    task automatic test_busy_ignore();
        int lows;
        start = 1'b1;
        bcd   = 16'h1234;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        bcd   = 16'h5678;
        tick();
        start = 1'b0;
        lows  = 2;
        while (!ready && lows < 20) begin
            lows++;
            tick();
        end
        n_cmp++;
        if (value !== 14'd1234 || lows !== DIGITS) begin
            n_bad++;
            $display("FAIL busy_value: value=%0d lows=%0d, want 1234/%0d", value, lows, DIGITS);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (ready !== 1'b1 || value !== 14'd1234) begin
                n_bad++;
                $display("FAIL busy_idle: ready=%0b value=%0d, want 1/1234", ready, value);
            end
        end
    endtask

    task automatic test_invalid_digit();
        int lows; logic [WIDTH-1:0] v; logic e; logic held;
        logic exp_e;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        do_conv(16'h12A4, lows, v, e, held);
        n_cmp++;
        if (v !== 14'd1304 || e !== exp_e) begin
            n_bad++;
            $display("FAIL invalid_12A4: value=%0d error=%0b, want 1304/%0b", v, e, exp_e);
        end
        do_conv(16'h0042, lows, v, e, held);
        n_cmp++;
        if (v !== 14'd42 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_0042: value=%0d error=%0b, want 42/0", v, e);
        end
    endtask

    task automatic test_reset_mid_run();
        int lows; logic [WIDTH-1:0] v; logic e; logic held;
        start = 1'b1;
        bcd   = 16'h4934;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || value !== '0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_abort: ready=%0b value=%0d error=%0b, want 1/0/0", ready, value, error);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || value !== '0) begin
            n_bad++;
            $display("FAIL midrun_noresult: ready=%0b value=%0d, want 1/0", ready, value);
        end
        do_conv(16'h0100, lows, v, e, held);
        n_cmp++;
        if (v !== 14'd100 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_0100: value=%0d error=%0b, want 100/0", v, e);
        end
    endtask

    task automatic test_random();
        int lows; logic [WIDTH-1:0] v; logic e; logic held;
        logic [4*DIGITS-1:0] b;
        for (int n = 0; n < 60; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                b[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            do_conv(b, lows, v, e, held);
            n_cmp++;
            if (v !== ref_value(b) || e !== ref_error(b) || lows !== DIGITS || held !== 1'b1) begin
                n_bad++;
                $display("FAIL random bcd=%h: value=%0d error=%0b lows=%0d held=%0b, want %0d/%0b/%0d/1",
                         b, v, e, lows, held, ref_value(b), ref_error(b), DIGITS);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_busy_ignore();
        test_invalid_digit();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from packed BCD digits to an unsigned binary value. It is the inverse of the `divide10` digit extractor: where `divide10` peels decimal digits off a binary value, this block rebuilds a binary value from decimal digits. It uses a multiply-by-10-and-add step, with one digit processed per clock. It sits between the keypad/digit-entry logic and the binary datapath that feeds the display counters, and uses the same `start`/`ready` handshake style as `divide10`.

## Interface

- `DIGITS`, default 4: number of BCD digits converted.
- `WIDTH`, default 14: binary result width; 14 holds 9999.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a conversion; sampled only while `ready`=1.
- `bcd`, input, 4*DIGITS: packed digits, most significant digit in the top nibble.
- `value`, output, WIDTH: converted binary result; registered.
- `ready`, output, 1: block is idle, and `value` holds the last completed result.
- `error`, output, 1: at least one digit of the last conversion was greater than 9; see Configuration.

## Operation

- States:
  - IDLE: `ready`=1.
  - RUN: `ready`=0.
- IDLE to RUN: on `start`=1. In the same edge:
  - latch `bcd` into a shift register;
  - clear the accumulator;
  - load the digit counter with DIGITS-1.
- RUN, every cycle:
  - acc <= (acc<<3) + (acc<<1) + top nibble, truncated to WIDTH bits;
  - shift the digit register left by 4;
  - decrement the counter.
- RUN to IDLE: when the counter is 0, after the final digit is accumulated. In the same edge:
  - `value` <= final accumulator result;
  - `error` <= digit-check result.
- `value` and `error` hold their previous result for the whole of RUN. They change only at completion.
- `start` while in RUN is ignored; there is no queuing.
- Changes to `bcd` after the accept edge have no effect.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. No overflow flag is produced.

## Timing

- Reset values: state IDLE, `ready`=1, `value`=0, `error`=0, accumulator and counter 0.
- Latency:
  - `start` sampled at edge N;
  - `ready` is low from N+1 through N+DIGITS;
  - `ready` is high again at N+DIGITS+1, with `value` valid at that edge.
- Throughput: one conversion per DIGITS+1 cycles. `start` held high continuously is accepted again on the first cycle `ready` is high.
- `rst` and `start` in the same cycle: reset wins, and the block stays in IDLE.
- `rst` during RUN: the conversion is aborted. The next cycle shows `ready`=1, `value`=0, `error`=0, and no result is produced.
- DIGITS=1: RUN lasts exactly one cycle.

## Configuration

- Macro: `BCD_TO_BINARY_DIGIT_CHECK_EN`.
- Defined:
  - each digit is compared against 9 as it is consumed;
  - a sticky flag is cleared on accept and set on any digit greater than 9;
  - the flag is copied to `error` at completion;
  - `value` is still computed using the raw nibble.
- Undefined:
  - no comparator logic is built;
  - `error` is constant 0;
  - invalid nibbles are accumulated as-is (0 to 15).

## Test plan

- Reset: assert `rst` for 2 cycles, then check `ready`=1, `value`=0, `error`=0.
- Nominal: `bcd`=16'h4934 with a 1-cycle `start`. Check `ready` is low for exactly 4 cycles, then `value`=4934 and `error`=0. Follow with 16'h0000, which must give `value`=0.
- Extremes and back-to-back: 16'h9999 must give 9999. Then hold `start` high with 16'h0001 and check it is accepted on the first cycle `ready` returns high, with `value`=1 after 5 more cycles.
- Busy ignore: accept 16'h1234, then pulse `start` with `bcd`=16'h5678 two cycles later. Check `value`=1234, no second conversion, and `ready` stays high afterwards.
- Invalid digit: 16'h12A4 must give `value`=1304. With the macro defined `error`=1; without it `error`=0. A following 16'h0042 must give `value`=42 and `error`=0.
- Reset mid-run: accept 16'h4934 and assert `rst` on the 2nd RUN cycle. Check the next cycle shows `ready`=1 and `value`=0. A new start with 16'h0100 must then give `value`=100.
